// File: rtl/mem_wb_stage_pipe.sv
// MEM/WB pipeline register: load-lane extraction, stall/flush control, x0 write
// suppression, committed-write history with two bypass read ports, retired counter.
module mem_wb_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int HIST_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_data_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic [RA_W-1:0]   rd_i,
    input  logic [RA_W-1:0]   rs1_addr_i,
    input  logic [RA_W-1:0]   rs2_addr_i,
    output logic              valid_o,
    output logic              reg_write_o,
    output logic [RA_W-1:0]   reg_RDaddr_o,
    output logic [XLEN-1:0]   reg_RDdata_o,
    output logic [RA_W-1:0]   forwarding_rd_o,
    output logic              byp1_hit_o,
    output logic [XLEN-1:0]   byp1_data_o,
    output logic              byp2_hit_o,
    output logic [XLEN-1:0]   byp2_data_o,
    output logic [CNT_W-1:0]  retired_cnt_o
);

    localparam int LANE_W = $clog2(XLEN / 8);

    // ------------------------------------------------------------------
    // Load data extraction
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] half_lane;
    logic [LANE_W-1:0] word_lane;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       word_v;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   sel_data;

    always_comb begin
        lane      = addr_data_i[LANE_W-1:0];
        half_lane = lane & ~LANE_W'(1);
        word_lane = lane & ~LANE_W'(3);
        byte_v    = 8'(mem_data_i >> {lane, 3'b000});
        half_v    = 16'(mem_data_i >> {half_lane, 3'b000});
        word_v    = 32'(mem_data_i >> {word_lane, 3'b000});
        case (funct3_i)
            3'b000:  load_data = XLEN'($signed(byte_v));
            3'b100:  load_data = XLEN'(byte_v);
            3'b001:  load_data = XLEN'($signed(half_v));
            3'b101:  load_data = XLEN'(half_v);
            3'b010:  load_data = XLEN'($signed(word_v));
            // On a 32-bit datapath LWU degenerates to LW (no bits to extend).
            3'b110:  load_data = (XLEN == 64) ? XLEN'(word_v) : XLEN'($signed(word_v));
            default: load_data = mem_data_i;
        endcase
        sel_data = mem_to_reg_i ? load_data : addr_data_i;
    end

    // ------------------------------------------------------------------
    // WB register next state
    // ------------------------------------------------------------------
    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              advance;
    logic              hist_shift;

    logic              hist_valid_q [HIST_DEPTH];
    logic [RA_W-1:0]   hist_rd_q    [HIST_DEPTH];
    logic [XLEN-1:0]   hist_data_q  [HIST_DEPTH];

    // The current WB instruction leaves the stage on any flush or non-stalled edge.
    assign advance    = flush_i | ~stall_i;
    assign hist_shift = advance & we_q;

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        rd_d    = rd_q;
        data_d  = data_q;
        cnt_d   = cnt_q + CNT_W'(valid_q & advance);
        if (flush_i) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            rd_d    = '0;
        end else if (!stall_i) begin
            valid_d = valid_i;
            we_d    = valid_i & reg_write_i & (rd_i != '0);
            rd_d    = rd_i;
            data_d  = sel_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_valid_q[i] <= 1'b0;
                hist_rd_q[i]    <= '0;
                hist_data_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            if (hist_shift) begin
                hist_valid_q[0] <= 1'b1;
                hist_rd_q[0]    <= rd_q;
                hist_data_q[0]  <= data_q;
                for (int i = 1; i < HIST_DEPTH; i++) begin
                    hist_valid_q[i] <= hist_valid_q[i-1];
                    hist_rd_q[i]    <= hist_rd_q[i-1];
                    hist_data_q[i]  <= hist_data_q[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bypass lookup: WB register first, then youngest history entry onward
    // ------------------------------------------------------------------
    logic [RA_W-1:0] rs_addr  [2];
    logic            byp_hit  [2];
    logic [XLEN-1:0] byp_data [2];

    assign rs_addr[0] = rs1_addr_i;
    assign rs_addr[1] = rs2_addr_i;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            byp_hit[p]  = 1'b0;
            byp_data[p] = '0;
            if (rs_addr[p] != '0) begin
                if (we_q && (rd_q == rs_addr[p])) begin
                    byp_hit[p]  = 1'b1;
                    byp_data[p] = data_q;
                end else begin
                    for (int i = 0; i < HIST_DEPTH; i++) begin
                        if (!byp_hit[p] && hist_valid_q[i] && (hist_rd_q[i] == rs_addr[p])) begin
                            byp_hit[p]  = 1'b1;
                            byp_data[p] = hist_data_q[i];
                        end
                    end
                end
            end
        end
    end

    assign valid_o         = valid_q;
    assign reg_write_o     = we_q;
    assign reg_RDaddr_o    = rd_q;
    assign reg_RDdata_o    = data_q;
    assign forwarding_rd_o = rd_q;
    assign retired_cnt_o   = cnt_q;
    assign byp1_hit_o      = byp_hit[0];
    assign byp1_data_o     = byp_data[0];
    assign byp2_hit_o      = byp_hit[1];
    assign byp2_data_o     = byp_data[1];

endmodule

// File: tb/tb_mem_wb_stage_pipe.sv
// Self-checking bench for mem_wb_stage_pipe (XLEN=32, HIST_DEPTH=2, CNT_W=4):
// a behavioural model pushes expected WB state per cycle, popped after each edge.
module tb_mem_wb_stage_pipe;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int HD   = 2;
    localparam int CW   = 4;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            stall_i, flush_i, valid_i, reg_write_i, mem_to_reg_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] addr_data_i, mem_data_i;
    logic [RA_W-1:0] rd_i, rs1_addr_i, rs2_addr_i;
    logic            valid_o, reg_write_o, byp1_hit_o, byp2_hit_o;
    logic [RA_W-1:0] reg_RDaddr_o, forwarding_rd_o;
    logic [XLEN-1:0] reg_RDdata_o, byp1_data_o, byp2_data_o;
    logic [CW-1:0]   retired_cnt_o;

    mem_wb_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W), .HIST_DEPTH(HD), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
        .funct3_i(funct3_i), .addr_data_i(addr_data_i), .mem_data_i(mem_data_i),
        .rd_i(rd_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .valid_o(valid_o), .reg_write_o(reg_write_o), .reg_RDaddr_o(reg_RDaddr_o),
        .reg_RDdata_o(reg_RDdata_o), .forwarding_rd_o(forwarding_rd_o),
        .byp1_hit_o(byp1_hit_o), .byp1_data_o(byp1_data_o),
        .byp2_hit_o(byp2_hit_o), .byp2_data_o(byp2_data_o),
        .retired_cnt_o(retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic            v;
        logic            we;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
        logic [CW-1:0]   cnt;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_txn    = 0;

    // model state
    logic            m_v, m_we;
    logic [RA_W-1:0] m_rd;
    logic [XLEN-1:0] m_data;
    logic [CW-1:0]   m_cnt;
    logic            h_v    [HD];
    logic [RA_W-1:0] h_rd   [HD];
    logic [XLEN-1:0] h_data [HD];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_we = 0; m_rd = 0; m_data = 0; m_cnt = 0;
        for (int i = 0; i < HD; i++) begin
            h_v[i] = 0; h_rd[i] = 0; h_data[i] = 0;
        end
    endtask

    function automatic logic [XLEN-1:0] ref_load(input logic [2:0] f3, input logic [XLEN-1:0] ad,
                                                 input logic [XLEN-1:0] md);
        logic [7:0] b [4];
        int ln, hl;
        for (int k = 0; k < 4; k++) b[k] = md[8*k +: 8];
        ln = int'(ad[1:0]);
        hl = ln & 2;
        case (f3)
            3'b000:  return {{24{b[ln][7]}}, b[ln]};
            3'b100:  return {24'h0, b[ln]};
            3'b001:  return {{16{b[hl+1][7]}}, b[hl+1], b[hl]};
            3'b101:  return {16'h0, b[hl+1], b[hl]};
            default: return md;
        endcase
    endfunction

    function automatic logic [XLEN:0] ref_byp(input logic [RA_W-1:0] rs);
        if (rs == 0) return '0;
        if (m_we && m_rd == rs) return {1'b1, m_data};
        for (int i = 0; i < HD; i++)
            if (h_v[i] && h_rd[i] == rs) return {1'b1, h_data[i]};
        return '0;
    endfunction

    // One clock: drive inputs at negedge, push model expectation, compare after posedge.
    task automatic cyc(input logic st, input logic fl, input logic v, input logic w, input logic m2r,
                       input logic [2:0] f3, input logic [XLEN-1:0] ad, input logic [XLEN-1:0] md,
                       input logic [RA_W-1:0] rd, input logic [RA_W-1:0] r1, input logic [RA_W-1:0] r2);
        wb_t e;
        logic [XLEN:0] b1, b2;
        @(negedge clk_i);
        stall_i = st; flush_i = fl; valid_i = v; reg_write_i = w; mem_to_reg_i = m2r;
        funct3_i = f3; addr_data_i = ad; mem_data_i = md; rd_i = rd;
        rs1_addr_i = r1; rs2_addr_i = r2;
        if (fl || !st) begin
            if (m_we) begin
                for (int i = HD - 1; i > 0; i--) begin
                    h_v[i] = h_v[i-1]; h_rd[i] = h_rd[i-1]; h_data[i] = h_data[i-1];
                end
                h_v[0] = 1; h_rd[0] = m_rd; h_data[0] = m_data;
            end
            if (m_v) m_cnt = m_cnt + 1'b1;
        end
        if (fl) begin
            m_v = 0; m_we = 0; m_rd = 0;
        end else if (!st) begin
            m_v = v; m_we = v && w && (rd != 0); m_rd = rd;
            m_data = m2r ? ref_load(f3, ad, md) : ad;
        end
        exp_q.push_back('{m_v, m_we, m_rd, m_data, m_cnt});
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        n_txn++;
        check("valid_o", 64'(valid_o), 64'(e.v));
        check("reg_write_o", 64'(reg_write_o), 64'(e.we));
        check("reg_RDaddr_o", 64'(reg_RDaddr_o), 64'(e.rd));
        check("forwarding_rd_o", 64'(forwarding_rd_o), 64'(e.rd));
        check("reg_RDdata_o", 64'(reg_RDdata_o), 64'(e.data));
        check("retired_cnt_o", 64'(retired_cnt_o), 64'(e.cnt));
        b1 = ref_byp(r1);
        b2 = ref_byp(r2);
        check("byp1", {31'h0, byp1_hit_o, byp1_data_o}, 64'(b1));
        check("byp2", {31'h0, byp2_hit_o, byp2_data_o}, 64'(b2));
        $display("txn %0d: st=%0b fl=%0b valid=%0b we=%0b rd=%0d data=%h cnt=%0d byp1=%0b/%h",
                 n_txn, st, fl, valid_o, reg_write_o, reg_RDaddr_o, reg_RDdata_o, retired_cnt_o,
                 byp1_hit_o, byp1_data_o);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 64'(valid_o), 64'h0);
        check({tag, "_we"}, 64'(reg_write_o), 64'h0);
        check({tag, "_rd"}, 64'(reg_RDaddr_o), 64'h0);
        check({tag, "_fwd"}, 64'(forwarding_rd_o), 64'h0);
        check({tag, "_data"}, 64'(reg_RDdata_o), 64'h0);
        check({tag, "_cnt"}, 64'(retired_cnt_o), 64'h0);
    endtask

    localparam logic [31:0] MD = 32'h80FF7F01;

    initial begin
        logic [CW-1:0] c0;
        rst_n_i = 0; stall_i = 0; flush_i = 0; valid_i = 0; reg_write_i = 0; mem_to_reg_i = 0;
        funct3_i = 0; addr_data_i = 0; mem_data_i = 0; rd_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
        model_reset();
        #22;
        check_zero_outputs("reset");
        @(negedge clk_i);
        rst_n_i = 1;

        // capture
        cyc(0, 0, 1, 1, 0, 3'b000, 32'h1234, 32'h0, 5'd7, 5'd7, 5'd0);
        check("cap_we", 64'(reg_write_o), 64'h1);
        check("cap_rd", 64'(reg_RDaddr_o), 64'd7);
        check("cap_fwd", 64'(forwarding_rd_o), 64'd7);
        check("cap_data", 64'(reg_RDdata_o), 64'h1234);

        // load extraction
        cyc(0, 0, 1, 1, 1, 3'b000, 32'd1, MD, 5'd1, 5'd7, 5'd1);
        check("lb_a1", 64'(reg_RDdata_o), 64'h0000007F);
        cyc(0, 0, 1, 1, 1, 3'b000, 32'd3, MD, 5'd2, 5'd1, 5'd2);
        check("lb_a3", 64'(reg_RDdata_o), 64'hFFFFFF80);
        cyc(0, 0, 1, 1, 1, 3'b100, 32'd2, MD, 5'd3, 5'd1, 5'd2);
        check("lbu_a2", 64'(reg_RDdata_o), 64'h000000FF);
        cyc(0, 0, 1, 1, 1, 3'b001, 32'd3, MD, 5'd4, 5'd3, 5'd7);
        check("lh_a3", 64'(reg_RDdata_o), 64'hFFFF80FF);
        cyc(0, 0, 1, 1, 1, 3'b101, 32'd0, MD, 5'd9, 5'd4, 5'd3);
        check("lhu_a0", 64'(reg_RDdata_o), 64'h00007F01);
        cyc(0, 0, 1, 1, 1, 3'b010, 32'd2, MD, 5'd10, 5'd9, 5'd4);
        cyc(0, 0, 1, 1, 1, 3'b111, 32'd1, MD, 5'd11, 5'd10, 5'd9);

        // x0 write suppression
        cyc(0, 0, 1, 1, 0, 3'b000, 32'h55, 32'h0, 5'd0, 5'd0, 5'd11);
        check("x0_we", 64'(reg_write_o), 64'h0);
        check("x0_valid", 64'(valid_o), 64'h1);

        // stall three cycles while new inputs are presented
        cyc(0, 0, 1, 1, 0, 3'b000, 32'hABCD, 32'h0, 5'd12, 5'd12, 5'd0);
        c0 = m_cnt;
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 1, 1, 0, 3'b000, 32'h9999 + i, 32'h0, 5'd13, 5'd12, 5'd13);
        check("stall_hold_data", 64'(reg_RDdata_o), 64'hABCD);
        check("stall_cnt_hold", 64'(retired_cnt_o), 64'(c0));
        cyc(0, 0, 1, 1, 0, 3'b000, 32'h7777, 32'h0, 5'd14, 5'd12, 5'd14);
        check("stall_cnt_inc1", 64'(retired_cnt_o), 64'(c0 + 1'b1));

        // flush with stall
        cyc(1, 1, 1, 1, 0, 3'b000, 32'h6666, 32'h0, 5'd15, 5'd14, 5'd12);
        check("flush_valid", 64'(valid_o), 64'h0);
        check("flush_we", 64'(reg_write_o), 64'h0);

        // bypass priority
        cyc(0, 0, 1, 1, 0, 3'b000, 32'hA, 32'h0, 5'd5, 5'd5, 5'd6);
        cyc(0, 0, 1, 1, 0, 3'b000, 32'hB, 32'h0, 5'd5, 5'd5, 5'd6);
        cyc(0, 0, 1, 1, 0, 3'b000, 32'hC, 32'h0, 5'd6, 5'd5, 5'd6);
        check("byp_hit_x5", 64'(byp1_hit_o), 64'h1);
        check("byp_data_x5", 64'(byp1_data_o), 64'hB);
        cyc(0, 0, 1, 1, 0, 3'b000, 32'hD, 32'h0, 5'd7, 5'd5, 5'd6);
        cyc(0, 0, 1, 1, 0, 3'b000, 32'hE, 32'h0, 5'd8, 5'd5, 5'd6);
        check("byp_miss_x5", 64'(byp1_hit_o), 64'h0);
        check("byp_miss_data", 64'(byp1_data_o), 64'h0);

        // asynchronous reset between edges
        @(posedge clk_i);
        #2;
        rst_n_i = 0;
        #1;
        check_zero_outputs("areset");
        model_reset();
        valid_i = 0; reg_write_i = 0; rd_i = 0; stall_i = 0; flush_i = 0;
        @(negedge clk_i);
        rst_n_i = 1;
        for (int r = 0; r < 32; r++) begin
            rs1_addr_i = 5'(r);
            rs2_addr_i = 5'(31 - r);
            #1;
            check("post_rst_byp1", {31'h0, byp1_hit_o, byp1_data_o}, 64'h0);
            check("post_rst_byp2", {31'h0, byp2_hit_o, byp2_data_o}, 64'h0);
        end

        // counter wrap: 17 retirements on a 4-bit counter
        for (int i = 0; i < 17; i++)
            cyc(0, 0, 1, (i % 3) != 0, 0, 3'b000, 32'(i * 3 + 1), 32'h0, 5'(i % 8 + 16), 5'd17, 5'd16);
        cyc(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd17, 5'd18);
        check("cnt_wrap", 64'(retired_cnt_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
